unidade_execucao: RTL and testbench

//  Execute stage downstream of the register bank: consumes its two read operands, runs one ALU or

---
 rtl/unidade_execucao.sv | 187 ++++++++++++++++++
 tb/tb_unidade_execucao.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_execucao.sv
// rtl/unidade_execucao.sv - execute stage: single-cycle ALU plus iterative MUL (and DIVU/REMU with EXEC_DIV_EN)
// Iterative ops stall issue via In_ready; results return to the register bank write port.
module unidade_execucao #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              Clock_in,
    input  logic              Signal_reset_n,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [3:0]        Op_code,
    input  logic [ADDR_W-1:0] Dest_address,
    input  logic [WIDTH-1:0]  Operand_a,
    input  logic [WIDTH-1:0]  Operand_b,
    output logic [WIDTH-1:0]  Data_to_write,
    output logic [ADDR_W-1:0] Address_to_write,
    output logic              Signal_write,
    output logic              Illegal_op,
    output logic              Busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DIV_RUN,
        S_WB
    } state_t;

    state_t             state_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [ADDR_W-1:0]  dest_q;
    logic [WIDTH-1:0]   data_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic               illegal_q;

    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_d;
    logic               op_single;
    logic               op_mul;

    assign shamt     = Operand_b[SHW-1:0];
    assign op_single = (Op_code <= 4'hA);
    assign op_mul    = (Op_code == 4'hB);

    always_comb begin
        alu_d = '0;
        case (Op_code)
            4'h0: alu_d = Operand_a + Operand_b;
            4'h1: alu_d = Operand_a - Operand_b;
            4'h2: alu_d = Operand_a & Operand_b;
            4'h3: alu_d = Operand_a | Operand_b;
            4'h4: alu_d = Operand_a ^ Operand_b;
            4'h5: alu_d = Operand_a << shamt;
            4'h6: alu_d = Operand_a >> shamt;
            4'h7: alu_d = $unsigned($signed(Operand_a) >>> shamt);
            4'h8: alu_d = {{(WIDTH-1){1'b0}}, ($signed(Operand_a) < $signed(Operand_b))};
            4'h9: alu_d = {{(WIDTH-1){1'b0}}, (Operand_a < Operand_b)};
            4'hA: alu_d = Operand_b;
            default: alu_d = '0;
        endcase
    end

`ifdef EXEC_DIV_EN
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   divisor_q;
    logic               sel_rem_q;
    logic               op_div;
    logic [WIDTH:0]     trial_d;
    logic [WIDTH:0]     diff_d;
    logic               ge_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;

    assign op_div = (Op_code == 4'hC) || (Op_code == 4'hD);

    // Restoring step; a zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    always_comb begin
        trial_d = {rem_q, quo_q[WIDTH-1]};
        diff_d  = trial_d - {1'b0, divisor_q};
        ge_d    = ~diff_d[WIDTH];
        rem_d   = ge_d ? diff_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge_d};
    end
`endif

    always_ff @(posedge Clock_in or negedge Signal_reset_n) begin
        if (!Signal_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            dest_q    <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
`ifdef EXEC_DIV_EN
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            sel_rem_q <= 1'b0;
`endif
        end else begin
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (In_valid) begin
                        if (op_single) begin
                            data_q  <= alu_d;
                            addr_q  <= Dest_address;
                            write_q <= 1'b1;
                        end else if (op_mul) begin
                            acc_q    <= '0;
                            mcand_q  <= Operand_a;
                            mplier_q <= Operand_b;
                            dest_q   <= Dest_address;
                            cnt_q    <= CNT_MAX;
                            state_q  <= S_MUL_RUN;
                        end
`ifdef EXEC_DIV_EN
                        else if (op_div) begin
                            rem_q     <= '0;
                            quo_q     <= Operand_a;
                            divisor_q <= Operand_b;
                            sel_rem_q <= Op_code[0];
                            dest_q    <= Dest_address;
                            cnt_q     <= CNT_MAX;
                            state_q   <= S_DIV_RUN;
                        end
`endif
                        else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_MUL_RUN: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= S_WB;
                    end
                end
`ifdef EXEC_DIV_EN
                S_DIV_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        acc_q   <= sel_rem_q ? rem_d : quo_d;
                        state_q <= S_WB;
                    end
                end
`endif
                // Final result is parked in acc_q by both iterative units.
                S_WB: begin
                    data_q  <= acc_q;
                    addr_q  <= dest_q;
                    write_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign In_ready         = (state_q == S_IDLE);
    assign Busy             = (state_q != S_IDLE);
    assign Data_to_write    = data_q;
    assign Address_to_write = addr_q;
    assign Signal_write     = write_q;
    assign Illegal_op       = illegal_q;

endmodule

// File: tb/tb_unidade_execucao.sv
// tb/tb_unidade_execucao.sv - directed table-driven bench for unidade_execucao
module tb_unidade_execucao;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] wdata;
    logic [3:0]  waddr;
    logic        wr;
    logic        illegal;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    unidade_execucao #(.WIDTH(32), .ADDR_W(4)) dut (
        .Clock_in(clk),
        .Signal_reset_n(rst_n),
        .In_valid(in_valid),
        .In_ready(in_ready),
        .Op_code(op),
        .Dest_address(dest),
        .Operand_a(opa),
        .Operand_b(opb),
        .Data_to_write(wdata),
        .Address_to_write(waddr),
        .Signal_write(wr),
        .Illegal_op(illegal),
        .Busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dest;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] d);
        in_valid = v;
        op       = o;
        opa      = a;
        opb      = b;
        dest     = d;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue an iterative op; expect a single write WIDTH+1 edges after acceptance.
    task automatic run_multi(input string nm, input logic [3:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] d, input logic [31:0] exp,
                             input bit stall_probe);
        int lat;
        int busy_cnt;
        drive(1'b1, o, a, b, d);
        cycle();
        chk({nm, "_ready_low"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_busy_high"}, {31'd0, busy}, 32'd1);
        if (stall_probe) drive(1'b1, 4'h0, 32'h1111_1111, 32'h2222_2222, ~d);
        else drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        lat = 0;
        busy_cnt = 0;
        while (!wr && lat < 40) begin
            if (busy && !in_ready) busy_cnt++;
            cycle();
            lat++;
        end
        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        chk({nm, "_latency"}, lat, 32'd33);
        chk({nm, "_stalled_throughout"}, busy_cnt, lat);
        chk({nm, "_data"}, wdata, exp);
        chk({nm, "_addr"}, {28'd0, waddr}, {28'd0, d});
        chk({nm, "_ready_after"}, {31'd0, in_ready}, 32'd1);
        cycle();
        chk({nm, "_single_write"}, {31'd0, wr}, 32'd0);
    endtask

    task automatic run_illegal(input string nm, input logic [3:0] o);
        drive(1'b1, o, 32'd5, 32'd6, 4'd2);
        cycle();
        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        chk({nm, "_illegal_pulse"}, {31'd0, illegal}, 32'd1);
        chk({nm, "_no_write"}, {31'd0, wr}, 32'd0);
        chk({nm, "_still_ready"}, {31'd0, in_ready}, 32'd1);
        cycle();
        chk({nm, "_illegal_clears"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        int writes;
        vecs[0]  = '{4'h1, 32'h0000_0000, 32'h0000_0001, 4'd1,  32'hFFFF_FFFF};
        vecs[1]  = '{4'h7, 32'h8000_0000, 32'h0000_0004, 4'd2,  32'hF800_0000};
        vecs[2]  = '{4'h8, 32'hFFFF_FFFF, 32'h0000_0000, 4'd3,  32'h0000_0001};
        vecs[3]  = '{4'h9, 32'hFFFF_FFFF, 32'h0000_0000, 4'd4,  32'h0000_0000};
        vecs[4]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5,  32'h0000_0000};
        vecs[5]  = '{4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6,  32'hF000_F000};
        vecs[6]  = '{4'h3, 32'hF0F0_F0F0, 32'h0F0F_0000, 4'd7,  32'hFFFF_F0F0};
        vecs[7]  = '{4'h4, 32'hAAAA_5555, 32'hFFFF_0000, 4'd8,  32'h5555_5555};
        vecs[8]  = '{4'h5, 32'h0000_0001, 32'h0000_0025, 4'd9,  32'h0000_0020};
        vecs[9]  = '{4'h6, 32'h8000_0000, 32'h0000_001F, 4'd10, 32'h0000_0001};
        vecs[10] = '{4'h7, 32'h7FFF_FFFF, 32'h0000_0004, 4'd11, 32'h07FF_FFFF};
        vecs[11] = '{4'hA, 32'h1234_5678, 32'h9ABC_DEF0, 4'd0,  32'h9ABC_DEF0};
        vecs[12] = '{4'h8, 32'h0000_0001, 32'hFFFF_FFFF, 4'd12, 32'h0000_0000};
        vecs[13] = '{4'h9, 32'h0000_0001, 32'hFFFF_FFFF, 4'd13, 32'h0000_0001};

        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("por_ready", {31'd0, in_ready}, 32'd1);
        chk("por_write", {31'd0, wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Produce a live write, then yank reset between edges.
        drive(1'b1, 4'h4, 32'h0000_00FF, 32'h0000_000F, 4'd7);
        @(posedge clk);
        #2;
        chk("pre_reset_write", {31'd0, wr}, 32'd1);
        chk("pre_reset_data", wdata, 32'h0000_00F0);
        rst_n = 1'b0;
        #1;
        chk("rst_write", {31'd0, wr}, 32'd0);
        chk("rst_data", wdata, 32'd0);
        chk("rst_addr", {28'd0, waddr}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        rst_n = 1'b1;
        cycle();

        drive(1'b1, 4'h0, 32'd5, 32'd7, 4'd3);
        cycle();
        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        chk("add_write", {31'd0, wr}, 32'd1);
        chk("add_data", wdata, 32'd12);
        chk("add_addr", {28'd0, waddr}, 32'd3);
        cycle();
        chk("add_strobe_drops", {31'd0, wr}, 32'd0);
        chk("add_data_holds", wdata, 32'd12);

        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
            cycle();
            chk($sformatf("vec%0d_write", i), {31'd0, wr}, 32'd1);
            chk($sformatf("vec%0d_data", i), wdata, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), {28'd0, waddr}, {28'd0, vecs[i].dest});
            chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, 32'd0);
        end
        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        cycle();
        chk("vec_tail_idle", {31'd0, wr}, 32'd0);

        run_multi("mul_small", 4'hB, 32'h0001_0003, 32'h0000_0005, 4'd9, 32'h0005_000F, 1'b1);
        run_multi("mul_ones", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0000_0001, 1'b0);

        // Abort a multiply once its counter has reached 10.
        drive(1'b1, 4'hB, 32'h0000_0007, 32'h0000_0009, 4'd4);
        cycle();
        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        repeat (21) cycle();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_write", {31'd0, wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        writes = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (wr) writes++;
        end
        chk("abort_no_write", writes, 32'd0);

        run_illegal("op_e", 4'hE);
        run_illegal("op_f", 4'hF);
`ifdef EXEC_DIV_EN
        run_multi("divu", 4'hC, 32'd100, 32'd7, 4'd5, 32'd14, 1'b0);
        run_multi("remu", 4'hD, 32'd100, 32'd7, 4'd6, 32'd2, 1'b0);
        run_multi("divu_zero", 4'hC, 32'd9, 32'd0, 4'd7, 32'hFFFF_FFFF, 1'b0);
        run_multi("remu_zero", 4'hD, 32'd9, 32'd0, 4'd8, 32'd9, 1'b0);
`else
        run_illegal("op_c", 4'hC);
        run_illegal("op_d", 4'hD);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
